actn_packer: RTL and testbench
==============================

# actn_packer

Sink-side companion to the feedforward processor set. Accepts the z/fi sigmoid and sigmoid-prime values the feedforward set produces each cycle, assembles fi consecutive slices into one z-wide activation word plus a matching z-wide sp word, and presents each word with an address on a valid/ready interface. Its output is the z-wide activation and sp word format that the next layer's feedforward set and the BP set consume, so finished activations can be written straight into the next layer's activation and sp memories.

## Interface
Parameters:
- fi, 4, fan-in; number of slices per assembled word
- z, 8, lanes per assembled word; must be divisible by fi
- n, 16, neurons in the produced layer; must be divisible by z; word count NW = n/z
- width, 16, bits per value (fixed point, passed through unmodified)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  slice present on inputs
- in_ready  out  1  slice accepted when in_valid && in_ready
- sigmoid_package  in  width*z/fi  z/fi activation values, lane j at bits [width*(j+1)-1:width*j]
- sp_package  in  width*z/fi  z/fi sigmoid-prime values, same lane layout
- out_valid  out  1  assembled word held on outputs
- out_ready  in  1  word consumed when out_valid && out_ready
- a_package  out  width*z  assembled activation word
- sp_out_package  out  width*z  assembled sp word
- addr  out  max(1,$clog2(NW))  word index within layer, 0..NW-1
- last  out  1  high with out_valid when addr == NW-1
- ovf_err  out  1  sticky protocol error flag (see Configuration)

## Operation
- Slice counter c ranges 0..fi-1. On each input handshake, input lane j is written to word lane c*(z/fi)+j in the packing registers, for both the activation and sp words. The first slice therefore lands in the lowest bits. c then increments, and wraps to 0 after fi-1.
- Accepting the slice with c == fi-1 completes the word. On that same edge the full packing contents, including the slice just arriving, transfer into the output register, and out_valid is set.
- The output register holds its contents stable while out_valid && !out_ready.
- in_ready = (c != fi-1) || !out_valid || out_ready. Partial slices are always accepted. The completing slice is blocked only when the output register is full and not draining.
- A completion and an output handshake on the same edge load the new word, and out_valid stays 1.
- An output handshake with no completion clears out_valid.
- The addr register increments on each output handshake and wraps from NW-1 to 0. last = out_valid && (addr == NW-1).
- With fi == 1, every accepted slice completes a word.
- Values pass through unmodified: no arithmetic, no saturation.
- Reset mid-word discards the partial slices.

## Timing
- Reset values: in_ready=1, out_valid=0, last=0, addr=0, ovf_err=0, a_package=0, sp_out_package=0, c=0, packing registers 0.
- Latency: out_valid rises 1 cycle after the handshake of the completing slice.
- Throughput: one word per fi cycles sustained, with no bubbles, when out_ready is held at 1.
- Backpressure: out_ready=0 stalls only the completing slice. The previous fi-1 slices may still be absorbed.
- in_ready is combinational from out_ready. No other combinational input-to-output paths.

## Configuration
- ACTN_PACKER_OVF_CHECK_EN defined: ovf_err is set on any cycle with in_valid && !in_ready && (sigmoid_package or sp_package changed vs. the previous cycle). This detects an upstream source that does not hold data under stall. The flag stays set until reset.
- ACTN_PACKER_OVF_CHECK_EN undefined: no check logic is built, and ovf_err is tied to 0. The port list is identical in both builds.

## Structure
- Shared package dnn_pkg holds:
  - the width/fi/z/n legality checks as localparam-derived constants
  - the NW and addr-width calculation
  - a lane-slice helper function computing lane offset c*(z/fi)+j
- One sub-module, actn_out_reg: holds the output register, the valid/ready hold logic and the addr/last counter.

## Test plan
- Defaults, out_ready=1, sigmoid lane values 1..8 over 4 slices (slice k lanes = 2k+1, 2k+2) -> one cycle after the 4th accept: a_package lanes 0..7 = 1..8, addr=0, last=0.
- Continue with a second word, values 9..16 -> addr=1, last=1. A third word -> addr wraps to 0 and last=0.
- Hold out_ready=0 after word 0 and feed 4 more slices -> slices 1-3 are accepted, in_ready=0 on slice 4. Word 0 stays stable. Raise out_ready -> word 0 handshakes, and word 1 becomes valid the next cycle.
- Simultaneous completion and drain (out_ready=1 on the completing edge) -> out_valid stays high continuously, words arrive back to back every 4 cycles.
- Assert reset after 2 slices -> all outputs are at reset values immediately. The next 4 slices form word 0 with no stale lanes.
- With ACTN_PACKER_OVF_CHECK_EN, change sigmoid_package while stalled -> ovf_err=1 and stays set. Without the macro, the same stimulus leaves ovf_err=0.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared helpers for the feedforward/activation datapath: legality checks,
// word-count and address-width calculation, and lane offset mapping.
package dnn_pkg;

    function automatic bit cfg_legal(int fi, int z, int n, int width);
        return (fi > 0) && (z > 0) && (width > 0) && (n >= z)
            && ((z % fi) == 0) && ((n % z) == 0);
    endfunction

    function automatic int calc_nw(int z, int n);
        return n / z;
    endfunction

    function automatic int calc_aw(int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

    // Lane within the assembled word for input lane j of slice c
    function automatic int lane_offset(int c, int j, int z, int fi);
        return c * (z / fi) + j;
    endfunction

endpackage

// File: rtl/actn_out_reg.sv
// Output stage of actn_packer: word register, valid/ready hold and the
// wrapping word address with its last flag.
module actn_out_reg #(
    parameter int word_w = 128,
    parameter int nw     = 2,
    parameter int aw     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [word_w-1:0] a_word,
    input  logic [word_w-1:0] sp_word,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [word_w-1:0] a_package,
    output logic [word_w-1:0] sp_out_package,
    output logic [aw-1:0]     addr,
    output logic              last
);

    localparam logic [aw-1:0] ADDR_MAX = aw'(nw - 1);

    logic drain;
    assign drain = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            a_package      <= '0;
            sp_out_package <= '0;
            addr           <= '0;
        end else begin
            if (load) begin
                out_valid      <= 1'b1;
                a_package      <= a_word;
                sp_out_package <= sp_word;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain)
                addr <= (addr == ADDR_MAX) ? '0 : addr + 1'b1;
        end
    end

    assign last = out_valid && (addr == ADDR_MAX);

endmodule

// File: rtl/actn_packer.sv
// Packs fi consecutive z/fi-lane slices into z-lane activation and sp words.
// Build option ACTN_PACKER_OVF_CHECK_EN adds a sticky stall-hold checker on ovf_err.
module actn_packer
    import dnn_pkg::*;
#(
    parameter int fi    = 4,
    parameter int z     = 8,
    parameter int n     = 16,
    parameter int width = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [width*z/fi-1:0]                    sigmoid_package,
    input  logic [width*z/fi-1:0]                    sp_package,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [width*z-1:0]                       a_package,
    output logic [width*z-1:0]                       sp_out_package,
    output logic [calc_aw(calc_nw(z, n))-1:0]        addr,
    output logic                                     last,
    output logic                                     ovf_err
);

    localparam bit CFG_OK  = cfg_legal(fi, z, n, width);
    localparam int NW      = calc_nw(z, n);
    localparam int AW      = calc_aw(NW);
    localparam int SLICE_W = width * z / fi;
    localparam int WORD_W  = width * z;
    localparam int CW      = (fi > 1) ? $clog2(fi) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(fi - 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("actn_packer: illegal fi/z/n/width combination");
        end
    endgenerate

    logic [CW-1:0]     c;
    logic [WORD_W-1:0] pack_a, pack_sp;
    logic [WORD_W-1:0] nxt_a, nxt_sp;
    logic              accept, complete;

    assign in_ready = (c != C_LAST) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (c == C_LAST);

    // Packing contents with the arriving slice merged in; this is also the
    // word handed to the output stage on the completing edge.
    always_comb begin
        nxt_a  = pack_a;
        nxt_sp = pack_sp;
        for (int k = 0; k < fi; k++) begin
            if (int'(c) == k) begin
                nxt_a[lane_offset(k, 0, z, fi)*width +: SLICE_W]  = sigmoid_package;
                nxt_sp[lane_offset(k, 0, z, fi)*width +: SLICE_W] = sp_package;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c       <= '0;
            pack_a  <= '0;
            pack_sp <= '0;
        end else if (accept) begin
            c       <= (c == C_LAST) ? '0 : c + 1'b1;
            pack_a  <= nxt_a;
            pack_sp <= nxt_sp;
        end
    end

    actn_out_reg #(
        .word_w (WORD_W),
        .nw     (NW),
        .aw     (AW)
    ) u_out_reg (
        .clk            (clk),
        .reset          (reset),
        .load           (complete),
        .a_word         (nxt_a),
        .sp_word        (nxt_sp),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .a_package      (a_package),
        .sp_out_package (sp_out_package),
        .addr           (addr),
        .last           (last)
    );

`ifdef ACTN_PACKER_OVF_CHECK_EN
    logic [SLICE_W-1:0] prev_sig, prev_sp;
    logic               ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sig <= '0;
            prev_sp  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            prev_sig <= sigmoid_package;
            prev_sp  <= sp_package;
            if (in_valid && !in_ready &&
                ((sigmoid_package != prev_sig) || (sp_package != prev_sp)))
                ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_actn_packer.sv
// Directed bench for actn_packer at default parameters (fi=4, z=8, n=16, width=16).
module tb_actn_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  sigmoid_package;
    logic [31:0]  sp_package;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] a_package;
    logic [127:0] sp_out_package;
    logic [0:0]   addr;
    logic         last;
    logic         ovf_err;

    int passed = 0;
    int total  = 0;

`ifdef ACTN_PACKER_OVF_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    actn_packer dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .sigmoid_package (sigmoid_package),
        .sp_package      (sp_package),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .a_package       (a_package),
        .sp_out_package  (sp_out_package),
        .addr            (addr),
        .last            (last),
        .ovf_err         (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Word whose lane i holds base+i
    function automatic logic [127:0] exp_word(input int base);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(base + i);
        return w;
    endfunction

    // Slice with lanes base, base+1; sp lanes offset by 100
    task automatic drive(input int base);
        for (int j = 0; j < 2; j++) begin
            sigmoid_package[j*16 +: 16] = 16'(base + j);
            sp_package[j*16 +: 16]      = 16'(base + 100 + j);
        end
    endtask

    task automatic feed(input int base);
        drive(base);
        in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sigmoid_package = '0; sp_package = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_last", last, 0);
        chk("rst_addr", addr, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_a", a_package, 0);
        chk("rst_sp", sp_out_package, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Word 0: values 1..8
        for (int k = 0; k < 3; k++) feed(1 + 2*k);
        chk("w0_partial_valid", out_valid, 0);
        feed(7);
        in_valid = 1'b0;
        chk("w0_valid", out_valid, 1);
        chk("w0_a", a_package, exp_word(1));
        chk("w0_sp", sp_out_package, exp_word(101));
        chk("w0_addr", addr, 0);
        chk("w0_last", last, 0);

        // Word 1: values 9..16
        feed(9);
        chk("w0_drained_valid", out_valid, 0);
        chk("w0_drained_addr", addr, 1);
        for (int k = 1; k < 4; k++) feed(9 + 2*k);
        in_valid = 1'b0;
        chk("w1_a", a_package, exp_word(9));
        chk("w1_addr", addr, 1);
        chk("w1_last", last, 1);

        // Word 2: address wraps
        for (int k = 0; k < 4; k++) feed(17 + 2*k);
        in_valid = 1'b0;
        chk("w2_a", a_package, exp_word(17));
        chk("w2_addr_wrap", addr, 0);
        chk("w2_last", last, 0);

        // Backpressure: partial slices absorbed, completing slice stalls
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(25 + 2*k); in_valid = 1'b1; #1;
            chk("bp_partial_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        drive(31); #1;
        chk("bp_stall_ready", in_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_a", a_package, exp_word(17));
        chk("bp_hold_addr", addr, 0);
        out_ready = 1'b1; #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_valid", out_valid, 1);
        chk("bp_new_a", a_package, exp_word(25));
        chk("bp_new_addr", addr, 1);
        chk("bp_new_last", last, 1);

        // Completion and drain on the same edge keeps out_valid high
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) feed(33 + 2*k);
        chk("sim_pre_valid", out_valid, 1);
        out_ready = 1'b1;
        feed(39);
        in_valid = 1'b0;
        chk("sim_valid", out_valid, 1);
        chk("sim_a", a_package, exp_word(33));
        chk("sim_sp", sp_out_package, exp_word(133));
        chk("sim_addr", addr, 0);

        // Reset mid-word
        feed(41);
        feed(43);
        in_valid = 1'b0;
        chk("mid_addr", addr, 1);
        #2 reset = 1'b1; #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_a", a_package, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) feed(51 + 2*k);
        in_valid = 1'b0;
        chk("post_rst_a", a_package, exp_word(51));
        chk("post_rst_sp", sp_out_package, exp_word(151));
        chk("post_rst_addr", addr, 0);

        // Stall-hold checker
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) feed(61 + 2*k);
        in_valid = 1'b0;
        drive(67);
        @(posedge clk); #1;
        in_valid = 1'b1; #1;
        chk("ovf_stall_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("ovf_held_clean", ovf_err, 0);
        sigmoid_package[15:0] = 16'hBEEF;
        @(posedge clk); #1;
        chk("ovf_flag", ovf_err, OVF_EXP);
        drive(67);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ovf_sticky", ovf_err, OVF_EXP);
        chk("ovf_word_a", a_package, exp_word(61));
        @(posedge clk); #1;
        chk("ovf_sticky2", ovf_err, OVF_EXP);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
